// File: rtl/mem_if_pkg.sv
// ============================================================================
// Module  : mem_if_pkg
// Brief   : Shared widths, error codes and responder state encoding for the
//           core memory interface.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_if_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_CONFLICT = 2'd1;
   localparam logic [1:0] ERR_DROP     = 2'd2;
   localparam logic [1:0] ERR_RANGE    = 2'd3;

   typedef enum logic [0:0] {
      ST_IDLE      = 1'b0,
      ST_READ_WAIT = 1'b1
   } resp_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_responder_read_latency_pipe.sv
// ============================================================================
// Module  : read_latency_pipe
// Brief   : Valid+data shift register; each data stage only loads on a valid
//           beat, so the last stage holds the most recent completed read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module read_latency_pipe
   import mem_if_pkg::*;
#(
   parameter int READ_LATENCY = 3,
   parameter int DATA_W       = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic [READ_LATENCY-1:0] r_valid;
   logic [DATA_W-1:0]       r_data [READ_LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         r_valid[0] <= i_valid;
         if (i_valid) begin
            r_data[0] <= i_data;
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_valid[i] <= r_valid[i-1];
            if (r_valid[i-1]) begin
               r_data[i] <= r_data[i-1];
            end
         end
      end
   end

   assign o_valid = r_valid[READ_LATENCY-1];
   assign o_data  = r_data[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module  : mem_responder
// Brief   : Fixed-latency read / single-cycle write responder over a word
//           array. Optional statistics via `define MEM_RESPONDER_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
   import mem_if_pkg::*;
#(
   parameter int DEPTH        = 1024,
   parameter int READ_LATENCY = 3,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              ren,
   input  logic              wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              rd_valid,
   output logic              wr_ack,
   output logic              busy,
   output logic [1:0]        err
`ifdef MEM_RESPONDER_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count,
   output logic [15:0]       err_count
`endif
);

   localparam int                c_CNT_W = $clog2(READ_LATENCY + 1);
   localparam logic [c_CNT_W-1:0] c_LAT   = c_CNT_W'(READ_LATENCY);
   localparam int                c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0]  r_mem [DEPTH];

   logic               r_prev_rd;
   logic               r_prev_wr;
   logic [ADDR_W-1:0]  r_prev_addr;
   logic [DATA_W-1:0]  r_prev_din;

   resp_state_e        r_state;
   resp_state_e        w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;

   logic               r_cap_valid;
   logic [DATA_W-1:0]  r_cap_data;

   logic               w_rd_req;
   logic               w_wr_req;
   logic               w_addr_chg;
   logic               w_rd_new;
   logic               w_wr_new;
   logic               w_in_range;
   logic               w_done;
   logic               w_can_accept;
   logic               w_rd_accept;
   logic               w_wr_commit;
   logic [1:0]         w_err_nxt;
   logic [c_IDX_W-1:0] w_idx;

   assign w_rd_req     = en & ren;
   assign w_wr_req     = en & wen;
   assign w_addr_chg   = (addr != r_prev_addr);
   assign w_rd_new     = w_rd_req & (~r_prev_rd | w_addr_chg);
   assign w_wr_new     = w_wr_req & (~r_prev_wr | w_addr_chg | (din != r_prev_din));
   assign w_in_range   = ({1'b0, addr} < c_DEPTH);
   assign w_idx        = addr[c_IDX_W-1:0];
   assign w_done       = (r_state == ST_READ_WAIT) && (r_cnt == c_LAT);
   // a read may be taken on the very edge the previous one completes
   assign w_can_accept = (r_state == ST_IDLE) | w_done;
   assign w_rd_accept  = w_rd_new & ~w_wr_req & w_can_accept;
   assign w_wr_commit  = w_wr_new & w_in_range;

   always_comb begin
      w_err_nxt = ERR_NONE;
      if ((w_rd_new | w_wr_new) & ~w_in_range) begin
         w_err_nxt = ERR_RANGE;
      end else if (w_rd_req & w_wr_req & (w_rd_new | w_wr_new)) begin
         w_err_nxt = ERR_CONFLICT;
      end else if (w_rd_new & ~w_wr_req & ~w_can_accept) begin
         w_err_nxt = ERR_DROP;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_commit) begin
         r_mem[w_idx] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_rd   <= 1'b0;
         r_prev_wr   <= 1'b0;
         r_prev_addr <= '0;
         r_prev_din  <= '0;
         r_cap_valid <= 1'b0;
         r_cap_data  <= '0;
         wr_ack      <= 1'b0;
         err         <= ERR_NONE;
      end else begin
         r_prev_rd   <= w_rd_req;
         r_prev_wr   <= w_wr_req;
         r_prev_addr <= addr;
         r_prev_din  <= din;
         r_cap_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_cap_data <= w_in_range ? r_mem[w_idx] : '0;
         end
         wr_ack      <= w_wr_commit;
         err         <= w_err_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_rd_accept) begin
               w_state_nxt = ST_READ_WAIT;
               w_cnt_nxt   = c_CNT_W'(1);
            end
         end
         ST_READ_WAIT: begin
            if (w_done) begin
               if (w_rd_accept) begin
                  w_cnt_nxt = c_CNT_W'(1);
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end
            end else if (r_cnt != c_LAT) begin
               w_cnt_nxt = r_cnt + c_CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      busy = (r_state == ST_READ_WAIT);
   end

   read_latency_pipe #(
      .READ_LATENCY (READ_LATENCY),
      .DATA_W       (DATA_W)
   ) u_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (r_cap_valid),
      .i_data  (r_cap_data),
      .o_valid (rd_valid),
      .o_data  (dout)
   );

`ifdef MEM_RESPONDER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count  <= '0;
         wr_count  <= '0;
         err_count <= '0;
      end else if (stats_clr) begin
         rd_count  <= '0;
         wr_count  <= '0;
         err_count <= '0;
      end else begin
         if (w_rd_accept) begin
            rd_count <= rd_count + 32'd1;
         end
         if (w_wr_commit) begin
            wr_count <= wr_count + 32'd1;
         end
         if (w_err_nxt != ERR_NONE) begin
            err_count <= err_count + 16'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module  : tb_mem_responder
// Brief   : Self-checking bench: vector table, directed corner sequences and
//           a randomized run against a cycle-count reference model.
//           Stats checks compile in with `define MEM_RESPONDER_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en, ren, wen;
   logic [15:0] addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        rd_valid, wr_ack, busy;
   logic [1:0]  err;
`ifdef MEM_RESPONDER_STATS_EN
   logic        stats_clr;
   logic [31:0] rd_count, wr_count;
   logic [15:0] err_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   mem_responder #(
      .DEPTH        (1024),
      .READ_LATENCY (LAT),
      .ADDR_W       (16),
      .DATA_W       (32)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .ren      (ren),
      .wen      (wen),
      .addr     (addr),
      .din      (din),
      .dout     (dout),
      .rd_valid (rd_valid),
      .wr_ack   (wr_ack),
      .busy     (busy),
      .err      (err)
`ifdef MEM_RESPONDER_STATS_EN
      ,
      .stats_clr (stats_clr),
      .rd_count  (rd_count),
      .wr_count  (wr_count),
      .err_count (err_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          en, ren, wen;
      logic [15:0] addr;
      logic [31:0] din;
      bit          e_rv, e_ack, e_busy;
      logic [1:0]  e_err;
      bit          chk_d;
      logic [31:0] e_dout;
   } vec_t;

   vec_t tbl [19];

   // reference model state (random phase)
   logic [31:0] m_mem   [1024];
   bit          m_known [1024];
   bit          m_inflight;
   int          m_due, m_n;
   bit          m_dk;
   logic [31:0] m_dd;
   bit          ed_known;
   logic [31:0] ed;
   bit          p_rd, p_wr;
   logic [15:0] p_addr;
   logic [31:0] p_din;
   int          m_rdc, m_wrc, m_errc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit e, input bit r, input bit w, input logic [15:0] a,
                        input logic [31:0] d);
      en = e; ren = r; wen = w; addr = a; din = d;
   endtask

   task automatic set_clr(input bit v);
`ifdef MEM_RESPONDER_STATS_EN
      stats_clr = v;
`else
      if (v) begin end
`endif
   endtask

   task automatic chk_counters(input string tag, input int rdc, input int wrc, input int errc);
`ifdef MEM_RESPONDER_STATS_EN
      chk({tag, "_rd_count"}, rd_count, rdc);
      chk({tag, "_wr_count"}, wr_count, wrc);
      chk({tag, "_err_count"}, {16'h0, err_count}, errc & 32'hFFFF);
`else
      if (tag.len() + rdc + wrc + errc < 0) begin end
`endif
   endtask

   task automatic mcycle();
      bit rdq, wrq, rnew, wnew, inr, acc, com, e_rv;
      logic [1:0] e_err;
      rdq  = en && ren;
      wrq  = en && wen;
      rnew = rdq && (!p_rd || addr != p_addr);
      wnew = wrq && (!p_wr || addr != p_addr || din != p_din);
      inr  = addr < 16'd1024;
      e_rv = m_inflight && (m_due == m_n);
      if (e_rv) begin
         m_inflight = 0;
         ed_known   = m_dk;
         ed         = m_dd;
      end
      if ((rnew || wnew) && !inr)             e_err = 2'd3;
      else if (rdq && wrq && (rnew || wnew))  e_err = 2'd1;
      else if (rnew && !wrq && m_inflight)    e_err = 2'd2;
      else                                    e_err = 2'd0;
      acc = rnew && !wrq && !m_inflight;
      if (acc) begin
         m_inflight = 1;
         m_due      = m_n + LAT;
         if (inr) begin
            m_dk = m_known[addr[9:0]];
            m_dd = m_mem[addr[9:0]];
         end else begin
            m_dk = 1;
            m_dd = 32'h0;
         end
         m_rdc++;
      end
      com = wnew && inr;
      if (com) begin
         m_mem[addr[9:0]]   = din;
         m_known[addr[9:0]] = 1;
         m_wrc++;
      end
      if (e_err != 2'd0) m_errc++;
      p_rd = rdq; p_wr = wrq; p_addr = addr; p_din = din;
      m_n++;
      tick();
      chk("rnd_rd_valid", {31'h0, rd_valid}, {31'h0, e_rv});
      chk("rnd_wr_ack",   {31'h0, wr_ack},   {31'h0, com});
      chk("rnd_busy",     {31'h0, busy},     {31'h0, m_inflight});
      chk("rnd_err",      {30'h0, err},      {30'h0, e_err});
      if (ed_known) chk("rnd_dout", dout, ed);
   endtask

   int rv_cnt, busy_cnt;

   initial begin
      tbl[0]  = '{1,0,1,16'd5,   32'hDEADBEEF, 0,1,0,2'd0, 1,32'h0};
      tbl[1]  = '{0,0,0,16'd0,   32'h0,        0,0,0,2'd0, 1,32'h0};
      tbl[2]  = '{1,1,0,16'd5,   32'h0,        0,0,1,2'd0, 1,32'h0};
      tbl[3]  = '{1,1,0,16'd5,   32'h0,        0,0,1,2'd0, 0,32'h0};
      tbl[4]  = '{1,1,0,16'd5,   32'h0,        0,0,1,2'd0, 0,32'h0};
      tbl[5]  = '{0,0,0,16'd0,   32'h0,        1,0,0,2'd0, 1,32'hDEADBEEF};
      tbl[6]  = '{0,0,0,16'd0,   32'h0,        0,0,0,2'd0, 1,32'hDEADBEEF};
      tbl[7]  = '{1,1,1,16'd9,   32'h1234,     0,1,0,2'd1, 1,32'hDEADBEEF};
      tbl[8]  = '{0,0,0,16'd0,   32'h0,        0,0,0,2'd0, 0,32'h0};
      tbl[9]  = '{1,1,0,16'd9,   32'h0,        0,0,1,2'd0, 0,32'h0};
      tbl[10] = '{0,0,0,16'd0,   32'h0,        0,0,1,2'd0, 0,32'h0};
      tbl[11] = '{0,0,0,16'd0,   32'h0,        0,0,1,2'd0, 0,32'h0};
      tbl[12] = '{0,0,0,16'd0,   32'h0,        1,0,0,2'd0, 1,32'h1234};
      tbl[13] = '{1,0,1,16'd1024,32'h55,       0,0,0,2'd3, 1,32'h1234};
      tbl[14] = '{0,0,0,16'd0,   32'h0,        0,0,0,2'd0, 0,32'h0};
      tbl[15] = '{1,1,0,16'd1024,32'h0,        0,0,1,2'd3, 0,32'h0};
      tbl[16] = '{0,0,0,16'd0,   32'h0,        0,0,1,2'd0, 0,32'h0};
      tbl[17] = '{0,0,0,16'd0,   32'h0,        0,0,1,2'd0, 0,32'h0};
      tbl[18] = '{0,0,0,16'd0,   32'h0,        1,0,0,2'd0, 1,32'h0};

      // reset state
      rst_n = 1'b0;
      set_clr(0);
      drive(0,0,0,16'd0,32'h0);
      tick(); tick();
      chk("rst_dout",     dout,                 32'h0);
      chk("rst_rd_valid", {31'h0, rd_valid},    32'h0);
      chk("rst_wr_ack",   {31'h0, wr_ack},      32'h0);
      chk("rst_busy",     {31'h0, busy},        32'h0);
      chk("rst_err",      {30'h0, err},         32'h0);
      chk_counters("rst", 0, 0, 0);
      rst_n = 1'b1;
      tick();

      // vector table: write/read, conflict, out of range
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].en, tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].din);
         tick();
         chk($sformatf("tbl%0d_rd_valid", i), {31'h0, rd_valid}, {31'h0, tbl[i].e_rv});
         chk($sformatf("tbl%0d_wr_ack", i),   {31'h0, wr_ack},   {31'h0, tbl[i].e_ack});
         chk($sformatf("tbl%0d_busy", i),     {31'h0, busy},     {31'h0, tbl[i].e_busy});
         chk($sformatf("tbl%0d_err", i),      {30'h0, err},      {30'h0, tbl[i].e_err});
         if (tbl[i].chk_d) chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
      end

      // new read while busy is dropped
      drive(1,0,1,16'd7,32'h77); tick();
      drive(1,0,1,16'd8,32'h88); tick();
      drive(0,0,0,16'd0,32'h0);  tick();
      drive(1,1,0,16'd7,32'h0);  tick();
      busy_cnt = busy;
      rv_cnt   = 0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 1) drive(1,1,0,16'd8,32'h0);
         else        drive(0,0,0,16'd0,32'h0);
         tick();
         if (k == 1) chk("drop_err", {30'h0, err}, 32'd2);
         if (rd_valid) begin
            rv_cnt++;
            chk("drop_dout", dout, 32'h77);
            chk("drop_rv_cycle", k, 3);
         end
         busy_cnt += busy;
      end
      chk("drop_rv_count", rv_cnt, 1);
      chk("drop_busy_cycles", busy_cnt, 3);

      // write to in-flight read address does not affect that read
      drive(1,0,1,16'd10,32'h11); tick();
      drive(0,0,0,16'd0,32'h0);   tick();
      drive(1,1,0,16'd10,32'h0);  tick();
      for (int k = 1; k <= 3; k++) begin
         if (k == 1) drive(1,0,1,16'd10,32'h22);
         else        drive(0,0,0,16'd0,32'h0);
         tick();
         if (k == 1) begin
            chk("wdr_wr_ack", {31'h0, wr_ack}, 32'd1);
            chk("wdr_err", {30'h0, err}, 32'd0);
         end
      end
      chk("wdr_rd_valid", {31'h0, rd_valid}, 32'd1);
      chk("wdr_dout_old", dout, 32'h11);

      // back-to-back reads: second accepted on the completion edge
      drive(1,1,0,16'd5,32'h0);  tick();
      drive(0,0,0,16'd0,32'h0);  tick(); tick();
      drive(1,1,0,16'd10,32'h0); tick();
      chk("b2b_rv1",   {31'h0, rd_valid}, 32'd1);
      chk("b2b_dout1", dout, 32'hDEADBEEF);
      chk("b2b_err",   {30'h0, err}, 32'd0);
      chk("b2b_busy",  {31'h0, busy}, 32'd1);
      drive(0,0,0,16'd0,32'h0);  tick(); tick(); tick();
      chk("b2b_rv2",   {31'h0, rd_valid}, 32'd1);
      chk("b2b_dout2", dout, 32'h22);

`ifdef MEM_RESPONDER_STATS_EN
      // clear wins over a same-cycle increment
      set_clr(1);
      drive(1,0,1,16'd3,32'h1); tick();
      set_clr(0);
      chk("clr_wr_ack", {31'h0, wr_ack}, 32'd1);
      chk_counters("clr", 0, 0, 0);
      drive(0,0,0,16'd0,32'h0); tick();
      drive(1,1,0,16'd3,32'h0); tick();
      drive(0,0,0,16'd0,32'h0); tick(); tick(); tick();
      chk_counters("post_clr", 1, 0, 0);
`endif

      // reset during an in-flight read
      drive(1,1,0,16'd5,32'h0); tick();
      drive(0,0,0,16'd0,32'h0); tick();
      chk("rmr_busy_pre", {31'h0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rmr_dout", dout, 32'h0);
      chk("rmr_busy", {31'h0, busy}, 32'd0);
      chk_counters("rmr", 0, 0, 0);
      tick(); tick();
      rst_n = 1'b1;
      rv_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         rv_cnt += rd_valid;
      end
      chk("rmr_no_rd_valid", rv_cnt, 0);

      // randomized run against the reference model
      set_clr(1); tick(); set_clr(0);
      m_inflight = 0; m_n = 0; m_due = 0; m_dk = 0; m_dd = 0;
      ed_known = 0; ed = 0;
      p_rd = 0; p_wr = 0; p_addr = 0; p_din = 0;
      m_rdc = 0; m_wrc = 0; m_errc = 0;
      for (int i = 0; i < 1024; i++) begin
         m_known[i] = 0;
         m_mem[i]   = 32'h0;
      end
      for (int a = 0; a < 16; a++) begin
         drive(1,0,1,16'(a),$urandom);
         mcycle();
      end
      drive(0,0,0,16'd0,32'h0);
      mcycle();
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0,9) >= 4) begin
            int pick;
            pick = $urandom_range(0,18);
            en   = ($urandom_range(0,9) != 0);
            ren  = $urandom_range(0,1) == 1;
            wen  = ($urandom_range(0,3) == 0);
            addr = (pick < 16) ? 16'(pick) : (pick == 16) ? 16'd1023 :
                   (pick == 17) ? 16'd1024 : 16'd2000;
            din  = $urandom_range(0,1) ? $urandom : 32'(pick);
         end
         mcycle();
      end
      chk_counters("rnd", m_rdc, m_wrc, m_errc);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
